// File: rtl/bist_stimulus_compactor.sv
// -----------------------------------------------------------------------------
// bist_stimulus_compactor
//
// BIST companion for a single-output circuit under test (CUT). A 16-bit Galois
// LFSR drives pseudo-random patterns onto the CUT inputs, and a 16-bit MISR
// folds the CUT response into a signature. At the end of a run the signature
// is compared against a golden value and the result is held until the next run.
//
// Ports:
//   I1470_clk  - clock, rising edge
//   I1477_rst  - asynchronous active-low reset
//   start      - run request, honoured only in IDLE and DONE
//   golden     - expected signature, sampled on the edge that enters DONE
//   resp       - CUT output
//   stim       - CUT input drive (LFSR low bits while running, else 0)
//   busy       - high while patterns are applied or the CUT pipeline drains
//   done       - high once the run has finished
//   pass       - signature matched golden (meaningful while done)
//   signature  - current MISR contents
//   state_dbg  - current FSM state encoding, for observation only
//
// Handshake: start is a level request; it is accepted on any rising edge where
// the FSM is in IDLE or DONE and start is high. There is no back-pressure.
// -----------------------------------------------------------------------------
module bist_stimulus_compactor #(
    parameter int          N_IN     = 3,
    parameter int          PATTERNS = 256,
    parameter int          LAT      = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic            I1470_clk,
    input  logic            I1477_rst,
    input  logic            start,
    input  logic [15:0]     golden,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     signature,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] POLY_MASK = 16'h6801;
    localparam logic [15:0] PAT_LAST  = 16'(PATTERNS - 1);
    localparam logic [15:0] LAT_LAST  = 16'(LAT - 1);

    // One Galois step of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] galois_step(input logic [15:0] v);
        return {v[14:0], 1'b0} ^ (v[15] ? POLY_MASK : 16'h0000);
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0]       misr_q, misr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              run_now;
    logic              misr_en;

    assign run_now = (state_q == S_RUN);

    // The "pattern valid" flag is delayed by the CUT latency so that each
    // response is captured exactly when the CUT presents it.
    generate
        if (LAT == 0) begin : g_no_delay
            assign misr_en = run_now;
        end else begin : g_delay
            logic [LAT-1:0] vld_q, vld_d;

            always_comb begin
                vld_d = LAT'({vld_q, run_now});
            end

            always_ff @(posedge I1470_clk or negedge I1477_rst) begin
                if (!I1477_rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            assign misr_en = vld_q[LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        if (misr_en) begin
            misr_d = galois_step(misr_q) ^ {15'b0, resp};
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = SEED;
                    misr_d  = 16'h0000;
                    cnt_d   = 16'h0000;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                lfsr_d = galois_step(lfsr_q);
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == PAT_LAST) begin
                    cnt_d = 16'h0000;
                    if (LAT == 0) begin
                        // Last capture happens on this same edge, so the
                        // comparison uses the updated MISR value.
                        state_d = S_DONE;
                        pass_d  = (misr_d == golden);
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = 16'h0000;
                    state_d = S_DONE;
                    pass_d  = (misr_d == golden);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next-state values so they line up
        // with the state they describe.
        stim_d = (state_d == S_RUN) ? lfsr_d[N_IN-1:0] : '0;
        busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            misr_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bist_stimulus_compactor.sv
// -----------------------------------------------------------------------------
// tb_bist_stimulus_compactor
//
// Five compactor instances with different pattern counts and CUT latencies run
// side by side from one start/reset. Each is paired with a small bench-side CUT
// (a register pipeline of LAT stages feeding a random 3-input truth table).
// Expected signatures come from a pattern-level model: walk the pattern
// sequence, look up each pattern's response, fold it into a signature.
//
// Instances: 0: P=4 L=1 resp=0 | 1: P=2 L=1 resp=1 | 2: P=256 L=1
//            3: P=30 L=3       | 4: P=25 L=0
// -----------------------------------------------------------------------------
module tb_bist_stimulus_compactor;

    localparam logic [15:0] SEED_V = 16'hACE1;
    localparam int          MAX_C  = 260;
    localparam int          NI     = 5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] gold_w [NI];
    logic        resp_w [NI];
    logic [2:0]  stim_w [NI];
    logic        busy_w [NI];
    logic        done_w [NI];
    logic        pass_w [NI];
    logic [15:0] sig_w  [NI];
    logic [1:0]  dbg_w  [NI];

    logic [7:0]  tt      [NI];
    logic [15:0] exp_sig [NI];
    logic        exp_pass[NI];

    int n_checks;
    int n_errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    bist_stimulus_compactor #(.N_IN(3), .PATTERNS(4), .LAT(1), .SEED(SEED_V)) u_dut0 (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .golden(gold_w[0]), .resp(resp_w[0]),
        .stim(stim_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .signature(sig_w[0]), .state_dbg(dbg_w[0]));
    bist_stimulus_compactor #(.N_IN(3), .PATTERNS(2), .LAT(1), .SEED(SEED_V)) u_dut1 (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .golden(gold_w[1]), .resp(resp_w[1]),
        .stim(stim_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .signature(sig_w[1]), .state_dbg(dbg_w[1]));
    bist_stimulus_compactor #(.N_IN(3), .PATTERNS(256), .LAT(1), .SEED(SEED_V)) u_dut2 (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .golden(gold_w[2]), .resp(resp_w[2]),
        .stim(stim_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .signature(sig_w[2]), .state_dbg(dbg_w[2]));
    bist_stimulus_compactor #(.N_IN(3), .PATTERNS(30), .LAT(3), .SEED(SEED_V)) u_dut3 (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .golden(gold_w[3]), .resp(resp_w[3]),
        .stim(stim_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
        .signature(sig_w[3]), .state_dbg(dbg_w[3]));
    bist_stimulus_compactor #(.N_IN(3), .PATTERNS(25), .LAT(0), .SEED(SEED_V)) u_dut4 (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .golden(gold_w[4]), .resp(resp_w[4]),
        .stim(stim_w[4]), .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]),
        .signature(sig_w[4]), .state_dbg(dbg_w[4]));

    // ---------------- bench-side CUTs ----------------
    logic [2:0] p1 [3];   // one-stage pipes for instances 0..2
    logic [2:0] d1, d2, d3; // three-stage pipe for instance 3

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1[0] <= 3'd0; p1[1] <= 3'd0; p1[2] <= 3'd0;
            d1 <= 3'd0; d2 <= 3'd0; d3 <= 3'd0;
        end else begin
            p1[0] <= stim_w[0]; p1[1] <= stim_w[1]; p1[2] <= stim_w[2];
            d1 <= stim_w[3]; d2 <= d1; d3 <= d2;
        end
    end

    assign resp_w[0] = tt[0][p1[0]];
    assign resp_w[1] = tt[1][p1[1]];
    assign resp_w[2] = tt[2][p1[2]];
    assign resp_w[3] = tt[3][d3];
    assign resp_w[4] = tt[4][stim_w[4]];

    // ---------------- reference model ----------------
    function automatic int pat_of(input int g);
        case (g)
            0: return 4;
            1: return 2;
            2: return 256;
            3: return 30;
            default: return 25;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        case (g)
            3: return 3;
            4: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] v);
        return {v[14:0], 1'b0} ^ (v[15] ? 16'h6801 : 16'h0000);
    endfunction

    // Signature after applying n patterns to a CUT with truth table t.
    function automatic logic [15:0] model_sig(input int n, input logic [7:0] t);
        logic [15:0] l;
        logic [15:0] m;
        l = SEED_V;
        m = 16'h0000;
        for (int k = 0; k < n; k++) begin
            m = galois(m) ^ {15'b0, t[l[2:0]]};
            l = galois(l);
        end
        return m;
    endfunction

    task automatic compute_expect();
        for (int g = 0; g < NI; g++) begin
            exp_sig[g] = model_sig(pat_of(g), tt[g]);
        end
    endtask

    task automatic settle_pass();
        for (int g = 0; g < NI; g++) begin
            exp_pass[g] = (gold_w[g] == exp_sig[g]);
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int g, input string what);
        chk($sformatf("%s_stim[%0d]", what, g), 32'(stim_w[g]), 32'd0);
        chk($sformatf("%s_busy[%0d]", what, g), 32'(busy_w[g]), 32'd0);
        chk($sformatf("%s_done[%0d]", what, g), 32'(done_w[g]), 32'd0);
        chk($sformatf("%s_pass[%0d]", what, g), 32'(pass_w[g]), 32'd0);
        chk($sformatf("%s_sig[%0d]",  what, g), 32'(sig_w[g]),  32'd0);
    endtask

    // One run from a start request. mid_start pulses start again during RUN;
    // abort_at (>0) asserts reset partway through; check_seq verifies the
    // first three stimulus words.
    task automatic do_run(input bit mid_start, input int abort_at, input bit check_seq);
        logic [15:0] e_l;
        logic [2:0]  seq [3];
        int          pl;
        seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b110;
        e_l   = SEED_V;
        start = 1'b1;
        for (int c = 1; c <= MAX_C; c++) begin
            tick();
            start = mid_start && (c == 2);
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                for (int g = 0; g < NI; g++) chk_idle(g, "abort");
                break;
            end
            if (check_seq && c <= 3) begin
                chk($sformatf("seq_stim_c%0d", c), 32'(stim_w[2]), 32'(seq[c-1]));
            end
            if (c <= 27) begin
                chk($sformatf("e_stim_c%0d", c), 32'(stim_w[4]), (c <= 25) ? 32'(e_l[2:0]) : 32'd0);
                if (c <= 25) e_l = galois(e_l);
            end
            for (int g = 0; g < NI; g++) begin
                pl = pat_of(g) + lat_of(g);
                if (c == 1 || c == pl) begin
                    chk($sformatf("busy_c%0d[%0d]", c, g), 32'(busy_w[g]), 32'd1);
                    chk($sformatf("done_c%0d[%0d]", c, g), 32'(done_w[g]), 32'd0);
                end
                if (c == pl + 1) begin
                    chk($sformatf("busy_end[%0d]", g), 32'(busy_w[g]), 32'd0);
                    chk($sformatf("done_end[%0d]", g), 32'(done_w[g]), 32'd1);
                    chk($sformatf("sig_end[%0d]",  g), 32'(sig_w[g]),  32'(exp_sig[g]));
                    chk($sformatf("pass_end[%0d]", g), 32'(pass_w[g]), 32'(exp_pass[g]));
                end
            end
        end
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        for (int g = 0; g < NI; g++) begin
            gold_w[g] = 16'h0000;
            tt[g]     = 8'h00;
        end
        tt[1] = 8'hFF;

        // Reset, then hold idle.
        repeat (3) tick();
        for (int g = 0; g < NI; g++) chk_idle(g, "rst");
        rst_n = 1'b1;
        repeat (3) tick();
        for (int g = 0; g < NI; g++) chk_idle(g, "hold");

        // Run 1: directed goldens on 0/1, model goldens elsewhere, one mismatch.
        tt[2] = 8'($urandom); tt[3] = 8'($urandom); tt[4] = 8'($urandom);
        compute_expect();
        gold_w[0] = 16'h0000;
        gold_w[1] = 16'h0003;
        gold_w[2] = exp_sig[2];
        gold_w[3] = exp_sig[3] ^ 16'($urandom_range(1, 65535));
        gold_w[4] = exp_sig[4];
        settle_pass();
        do_run(1'b0, 0, 1'b1);
        chk("a_sig_lit",  32'(sig_w[0]),  32'h0000);
        chk("a_pass_lit", 32'(pass_w[0]), 32'd1);
        chk("b_sig_lit",  32'(sig_w[1]),  32'h0003);
        chk("b_pass_lit", 32'(pass_w[1]), 32'd1);

        // Run 2: restart from DONE, stray start during RUN, wrong golden on 1.
        tt[2] = 8'($urandom); tt[3] = 8'($urandom); tt[4] = 8'($urandom);
        compute_expect();
        gold_w[1] = 16'h0002;
        gold_w[2] = ($urandom_range(0, 1) == 1) ? exp_sig[2] : ~exp_sig[2];
        gold_w[3] = exp_sig[3];
        gold_w[4] = exp_sig[4] ^ 16'h8000;
        settle_pass();
        do_run(1'b1, 0, 1'b0);
        chk("b_pass_bad_gold", 32'(pass_w[1]), 32'd0);

        // Run 3: reset partway through RUN, then a clean run with the same CUTs.
        tt[2] = 8'($urandom); tt[3] = 8'($urandom); tt[4] = 8'($urandom);
        compute_expect();
        gold_w[2] = exp_sig[2];
        settle_pass();
        do_run(1'b0, 100, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int g = 0; g < NI; g++) chk_idle(g, "post_abort");
        do_run(1'b0, 0, 1'b1);
        chk("c_sig_rerun",  32'(sig_w[2]),  32'(exp_sig[2]));
        chk("c_pass_rerun", 32'(pass_w[2]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bist_stimulus_compactor.md
# bist_stimulus_compactor

Built-in self-test companion for the extracted NT-node subcircuits in the trojan-detection benchmark set. The block is the opposite end of each subcircuit under test (CUT): it generates pseudo-random stimulus on the CUT's primary inputs and compacts the CUT's single output into a signature. It sits beside each CUT in the benchmark harness, shares the CUT clock and reset, and reports pass/fail against a golden signature so that trojan-modified netlists are flagged.

## Interface
- N_IN, 3, stimulus width (number of CUT data inputs driven)
- PATTERNS, 256, patterns applied per run (1..65535)
- LAT, 1, CUT register depth from input to output, in cycles (0..7)
- SEED, 16'hACE1, LFSR load value (must be nonzero)
- I1470_clk  input  1  clock, rising edge
- I1477_rst  input  1  asynchronous active-low reset
- start  input  1  run request; sampled in IDLE and DONE only
- golden  input  16  expected signature; sampled at the FLUSH->DONE transition
- resp  input  1  CUT output
- stim  output  N_IN  CUT input drive = lfsr[N_IN-1:0] in RUN, else 0
- busy  output  1  high in RUN and FLUSH
- done  output  1  high in DONE
- pass  output  1  registered (signature == golden); valid while done
- signature  output  16  current MISR contents

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'h6801. next = {l[14:0],1'b0} ^ (l[15] ? 16'h6801 : 0). Advances once per RUN cycle; loaded with SEED on reset and on every accepted start.
- MISR: same polynomial/mask. When enabled, next = {m[14:0],1'b0} ^ (m[15] ? 16'h6801 : 0) ^ {15'b0, resp}. Cleared to 0 on reset and on accepted start.
- MISR enable is the "stim valid" flag (1 in RUN) delayed by LAT cycles through a shift register; LAT=0 means same-cycle capture. Each applied pattern is compacted exactly once.
- Pattern counter: 16-bit, counts RUN cycles. The FSM leaves RUN when the count reaches PATTERNS.
- FSM states:
  - IDLE: start=1 -> RUN (load seed, clear MISR/counter).
  - RUN: after PATTERNS cycles -> FLUSH if LAT>0, else DONE.
  - FLUSH: LAT cycles -> DONE.
  - DONE: pass latched on entry; start=1 -> RUN (re-arm as from IDLE).
- start is ignored in RUN and FLUSH.
- Reset values: state IDLE, stim 0, busy 0, done 0, pass 0, signature 16'h0000, lfsr SEED, counter 0, valid delay line 0.
- Reset asserted mid-run aborts immediately and asynchronously; no partial signature is retained.

## Timing
- Start accepted at edge E0. RUN occupies cycles E0+1..E0+PATTERNS; stim changes each edge.
- busy rises at E0+1. done rises at E0+1+PATTERNS+LAT, simultaneous with busy falling. No idle gap.
- The MISR final update coincides with the last FLUSH cycle. signature is stable from done onward.
- pass and done assert on the same edge. pass reflects golden as sampled on that edge.
- A start held high in DONE retriggers every time DONE is entered: back-to-back runs with one DONE cycle between them.

## Test plan
- Reset, then hold: stim=0, busy=0, done=0, pass=0, signature=0x0000.
- SEED=0xACE1, N_IN=3, start pulse: stim sequence over the first three RUN cycles is 3'b001, 3'b011, 3'b110 (LFSR 0xACE1, 0x31C3, 0x6386).
- PATTERNS=4, LAT=1, resp tied 0, golden=0x0000, start at cycle 0: busy high in cycles 1–5, done high at cycle 6, signature 0x0000, pass=1.
- PATTERNS=2, LAT=1, resp tied 1: signature=0x0003. With golden=0x0003, pass=1; with golden=0x0002, pass=0.
- Reset pulse in the middle of RUN (PATTERNS=256): all outputs return to reset values immediately. A fresh start reproduces the same signature as an uninterrupted run.
- start pulsed during RUN: no effect on counter, signature, or done time. start in DONE: a new run begins, and done drops on the next edge.
